// File: rtl/axil_mem_arbiter_pkg.sv
// Shared response codes, FSM state encodings and grant identifiers for the
// AXI4-Lite register-memory arbiter.
package axil_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_CAPT  = 3'd2,
    RD_RESP  = 3'd3,
    WR_ISSUE = 3'd4,
    WR_CAPT  = 3'd5,
    WR_RESP  = 3'd6
  } state_t;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_t;

endpackage

// File: rtl/axil_req_hold.sv
// One-deep pending register for a request pulse and its payload. A pulse in
// the same cycle as the clear is accepted; a pulse while still pending is dropped.
module axil_req_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             clear,
  output logic             pending,
  output logic [WIDTH-1:0] dout,
  output logic             drop
);

  logic accept;

  assign accept = en && (!pending || clear);
  assign drop   = en && pending && !clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      dout    <= '0;
    end else if (accept) begin
      pending <= 1'b1;
      dout    <= din;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/axil_mem_arbiter.sv
// Round-robin arbiter sharing the single-port register memory between the
// read and write request paths, with registered responses and memory strobes.
module axil_mem_arbiter
  import axil_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_busy,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    wr_busy,
  output logic                    rresp_valid,
  output logic [1:0]              rresp,
  output logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    rresp_ready,
  output logic                    bresp_valid,
  output logic [1:0]              bresp,
  input  logic                    bresp_ready,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_err,
  output logic                    ovf_err
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int WR_PAY     = ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH = MEM_DEPTH[ADDR_WIDTH:0];

  state_t                  state, state_n;
  grant_t                  last_grant;
  logic                    grant_rd, grant_wr;
  logic                    rd_drop, wr_drop;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, wr_addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic [STRB_WIDTH-1:0]   wr_strb_q;
  logic [WR_PAY-1:0]       wr_pay_q;
  logic                    rd_oor, wr_oor;

  axil_req_hold #(.WIDTH(ADDR_WIDTH)) u_rd_hold (
    .clk     (clk),
    .reset   (reset),
    .en      (rd_en),
    .din     (rd_addr),
    .clear   (grant_rd),
    .pending (rd_busy),
    .dout    (rd_addr_q),
    .drop    (rd_drop)
  );

  axil_req_hold #(.WIDTH(WR_PAY)) u_wr_hold (
    .clk     (clk),
    .reset   (reset),
    .en      (wr_en),
    .din     ({wr_addr, wr_data, wr_strb}),
    .clear   (grant_wr),
    .pending (wr_busy),
    .dout    (wr_pay_q),
    .drop    (wr_drop)
  );

  assign {wr_addr_q, wr_data_q, wr_strb_q} = wr_pay_q;
  assign rd_oor = {1'b0, rd_addr_q} >= DEPTH;
  assign wr_oor = {1'b0, wr_addr_q} >= DEPTH;

  // Out-of-range requests skip the memory and go straight to a DECERR response.
  always_comb begin
    state_n  = state;
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    case (state)
      IDLE: begin
        if (rd_busy && (!wr_busy || last_grant == GRANT_WR)) begin
          grant_rd = 1'b1;
          state_n  = rd_oor ? RD_RESP : RD_ISSUE;
        end else if (wr_busy) begin
          grant_wr = 1'b1;
          state_n  = wr_oor ? WR_RESP : WR_ISSUE;
        end
      end
      RD_ISSUE: state_n = RD_CAPT;
      RD_CAPT:  state_n = RD_RESP;
      RD_RESP:  if (rresp_ready) state_n = IDLE;
      WR_ISSUE: state_n = WR_CAPT;
      WR_CAPT:  state_n = WR_RESP;
      WR_RESP:  if (bresp_ready) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= GRANT_WR;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      rresp_valid <= 1'b0;
      rresp       <= 2'b00;
      rdata       <= '0;
      bresp_valid <= 1'b0;
      bresp       <= 2'b00;
      ovf_err     <= 1'b0;
    end else begin
      state       <= state_n;
      mem_en      <= (state_n == RD_ISSUE) || (state_n == WR_ISSUE);
      mem_we      <= (state_n == WR_ISSUE);
      rresp_valid <= (state_n == RD_RESP);
      bresp_valid <= (state_n == WR_RESP);
      ovf_err     <= ovf_err | rd_drop | wr_drop;
      if (grant_rd) begin
        last_grant <= GRANT_RD;
        mem_addr   <= rd_addr_q;
        if (rd_oor) begin
          rresp <= RESP_DECERR;
          rdata <= '0;
        end
      end
      if (grant_wr) begin
        last_grant <= GRANT_WR;
        mem_addr   <= wr_addr_q;
        mem_wdata  <= wr_data_q;
        mem_wstrb  <= wr_strb_q;
        if (wr_oor) bresp <= RESP_DECERR;
      end
      if (state == RD_CAPT) begin
        rdata <= mem_rdata;
        rresp <= mem_err ? RESP_SLVERR : RESP_OKAY;
      end
      if (state == WR_CAPT) bresp <= mem_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// Self-checking bench for axil_mem_arbiter: a table of single transactions
// plus directed sequences for arbitration, stalls, overflow and reset abort.
module tb_axil_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en, wr_en;
  logic [4:0]  rd_addr, wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_busy, wr_busy;
  logic        rresp_valid, bresp_valid;
  logic [1:0]  rresp, bresp;
  logic [31:0] rdata;
  logic        rresp_ready, bresp_ready;
  logic        mem_en, mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        ovf_err;
  logic [83:0] allOut;

  int errors = 0;
  int checks = 0;

  logic [31:0] memModel [0:31];
  logic        errNext;

  axil_mem_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .MEM_DEPTH(24)) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_strb     (wr_strb),
    .wr_busy     (wr_busy),
    .rresp_valid (rresp_valid),
    .rresp       (rresp),
    .rdata       (rdata),
    .rresp_ready (rresp_ready),
    .bresp_valid (bresp_valid),
    .bresp       (bresp),
    .bresp_ready (bresp_ready),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .mem_err     (mem_err),
    .ovf_err     (ovf_err)
  );

  assign allOut = {rd_busy, wr_busy, rresp_valid, rresp, rdata, bresp_valid, bresp,
                   mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, ovf_err};

  always #5 clk = ~clk;

  // Memory model: data and error are returned one cycle after mem_en.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) memModel[i] <= 32'h01010101 * i;
      memModel[3] <= 32'hDEADBEEF;
      mem_rdata   <= 32'h0;
      mem_err     <= 1'b0;
    end else begin
      mem_err <= mem_en && errNext;
      if (mem_en) begin
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) memModel[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end else begin
          mem_rdata <= memModel[mem_addr];
        end
      end
    end
  end

  typedef struct {
    logic        isWrite;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        errIn;
    logic [1:0]  expResp;
    logic [31:0] expData;
    int          expIssue;
    int          expValid;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, output int issueK, output logic issueWe,
                               output logic [4:0] issueAddr, output logic [31:0] issueWdata,
                               output logic [3:0] issueStrb, output int validK,
                               output logic [1:0] resp, output logic [31:0] data,
                               output logic validAfter);
    @(negedge clk);
    errNext = v.errIn;
    if (v.isWrite) begin
      wr_en = 1'b1; wr_addr = v.addr; wr_data = v.data; wr_strb = v.strb;
    end else begin
      rd_en = 1'b1; rd_addr = v.addr;
    end
    issueK = -1; validK = -1;
    issueWe = 1'b0; issueAddr = '0; issueWdata = '0; issueStrb = '0;
    resp = 2'b00; data = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin rd_en = 1'b0; wr_en = 1'b0; end
      if (mem_en && issueK < 0) begin
        issueK = k; issueWe = mem_we; issueAddr = mem_addr;
        issueWdata = mem_wdata; issueStrb = mem_wstrb;
      end
      if (v.isWrite ? bresp_valid : rresp_valid) begin
        validK = k;
        resp   = v.isWrite ? bresp : rresp;
        data   = rdata;
        break;
      end
    end
    @(negedge clk);
    validAfter = v.isWrite ? bresp_valid : rresp_valid;
    errNext = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          issueK, validK, cnt;
    logic        issueWe, validAfter, seen;
    logic [4:0]  issueAddr;
    logic [31:0] issueWdata, data;
    logic [3:0]  issueStrb, orderBits;
    logic [1:0]  resp;
    logic [9:0]  addrBits;
    string       nm;

    vecs[0] = '{1'b1, 5'd7,  32'h12345678, 4'hF, 1'b0, 2'b00, 32'h0,        2, 4};
    vecs[1] = '{1'b0, 5'd7,  32'h0,        4'h0, 1'b0, 2'b00, 32'h12345678, 2, 4};
    vecs[2] = '{1'b0, 5'd3,  32'h0,        4'h0, 1'b0, 2'b00, 32'hDEADBEEF, 2, 4};
    vecs[3] = '{1'b0, 5'd30, 32'h0,        4'h0, 1'b0, 2'b11, 32'h0,       -1, 2};
    vecs[4] = '{1'b1, 5'd25, 32'h55555555, 4'hF, 1'b0, 2'b11, 32'h0,       -1, 2};
    vecs[5] = '{1'b1, 5'd3,  32'hAABBCCDD, 4'h5, 1'b0, 2'b00, 32'h0,        2, 4};
    vecs[6] = '{1'b0, 5'd3,  32'h0,        4'h0, 1'b0, 2'b00, 32'hDEBBBEDD, 2, 4};
    vecs[7] = '{1'b0, 5'd23, 32'h0,        4'h0, 1'b0, 2'b00, 32'h17171717, 2, 4};
    vecs[8] = '{1'b0, 5'd24, 32'h0,        4'h0, 1'b0, 2'b11, 32'h0,       -1, 2};
    vecs[9] = '{1'b1, 5'd10, 32'hCAFEF00D, 4'hF, 1'b1, 2'b10, 32'h0,        2, 4};

    reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; rd_addr = '0; wr_addr = '0;
    wr_data = '0; wr_strb = '0; rresp_ready = 1'b1; bresp_ready = 1'b1; errNext = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset outputs", 128'(allOut), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post-reset idle", 128'(allOut), 128'(0));

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], issueK, issueWe, issueAddr, issueWdata, issueStrb,
                    validK, resp, data, validAfter);
      nm = $sformatf("v%0d", i);
      checkOutput({nm, " issue cycle"}, 128'(issueK), 128'(vecs[i].expIssue));
      checkOutput({nm, " valid cycle"}, 128'(validK), 128'(vecs[i].expValid));
      checkOutput({nm, " resp"}, 128'(resp), 128'(vecs[i].expResp));
      checkOutput({nm, " valid dropped"}, 128'(validAfter), 128'(0));
      if (!vecs[i].isWrite) checkOutput({nm, " rdata"}, 128'(data), 128'(vecs[i].expData));
      if (vecs[i].expIssue > 0) begin
        checkOutput({nm, " mem_we"}, 128'(issueWe), 128'(vecs[i].isWrite));
        checkOutput({nm, " mem_addr"}, 128'(issueAddr), 128'(vecs[i].addr));
        if (vecs[i].isWrite) begin
          checkOutput({nm, " mem_wdata"}, 128'(issueWdata), 128'(vecs[i].data));
          checkOutput({nm, " mem_wstrb"}, 128'(issueStrb), 128'(vecs[i].strb));
        end
      end
    end

    // Simultaneous requests, twice: expect read, write, read, write.
    orderBits = '0; cnt = 0;
    for (int pair = 0; pair < 2; pair++) begin
      @(negedge clk);
      rd_en = 1'b1; rd_addr = 5'd5;
      wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h00000066; wr_strb = 4'hF;
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (k == 1) begin
          rd_en = 1'b0; wr_en = 1'b0;
          checkOutput($sformatf("pair%0d both busy", pair), 128'({rd_busy, wr_busy}), 128'(2'b11));
        end
        if (mem_en) begin orderBits = {orderBits[2:0], mem_we}; cnt++; end
      end
    end
    checkOutput("arb grant count", 128'(cnt), 128'(4));
    checkOutput("arb order", 128'(orderBits), 128'(4'b0101));
    checkOutput("arb no overflow", 128'(ovf_err), 128'(0));

    // Pulse in the same cycle as the clear is accepted, not dropped.
    addrBits = '0; cnt = 0;
    @(negedge clk);
    rd_en = 1'b1; rd_addr = 5'd1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) rd_addr = 5'd2;
      if (k == 2) rd_en = 1'b0;
      if (mem_en && !mem_we) begin addrBits = {addrBits[4:0], mem_addr}; cnt++; end
    end
    checkOutput("clear+pulse reads", 128'(cnt), 128'(2));
    checkOutput("clear+pulse addrs", 128'(addrBits), 128'({5'd1, 5'd2}));
    checkOutput("clear+pulse no ovf", 128'(ovf_err), 128'(0));

    // SLVERR read held with ready low while a write waits behind it.
    rresp_ready = 1'b0; errNext = 1'b1; validK = -1;
    @(negedge clk);
    rd_en = 1'b1; rd_addr = 5'd2;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) rd_en = 1'b0;
      if (rresp_valid) begin validK = k; break; end
    end
    errNext = 1'b0;
    checkOutput("slverr valid cycle", 128'(validK), 128'(4));
    checkOutput("slverr resp", 128'(rresp), 128'(2'b10));
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000C0DE; wr_strb = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      checkOutput($sformatf("stall hold %0d", k), 128'({rresp_valid, rresp, rdata, mem_en}),
                  128'({1'b1, 2'b10, 32'h02020202, 1'b0}));
    end
    checkOutput("stall write waiting", 128'(wr_busy), 128'(1));
    rresp_ready = 1'b1;
    validK = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bresp_valid) begin validK = k; break; end
    end
    checkOutput("after stall write resp seen", 128'(validK > 0), 128'(1));
    checkOutput("after stall bresp", 128'(bresp), 128'(2'b00));
    @(negedge clk);

    // Second read pulse while the first is still pending behind a write.
    checkOutput("ovf clear before", 128'(ovf_err), 128'(0));
    addrBits = '0; cnt = 0;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd13; wr_data = 32'h13131313; wr_strb = 4'hF;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) begin wr_en = 1'b0; rd_en = 1'b1; rd_addr = 5'd4; end
      if (k == 2) rd_addr = 5'd5;
      if (k == 3) rd_en = 1'b0;
      if (mem_en && !mem_we) begin addrBits = {addrBits[4:0], mem_addr}; cnt++; end
    end
    checkOutput("ovf read count", 128'(cnt), 128'(1));
    checkOutput("ovf read addr", 128'(addrBits[4:0]), 128'(5'd4));
    checkOutput("ovf sticky", 128'(ovf_err), 128'(1));

    // Reset during WR_CAPT with a read pending: everything drops immediately.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99999999; wr_strb = 4'hF;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 5'd0;
    @(negedge clk);
    rd_en = 1'b0;
    checkOutput("pre-reset write issue", 128'({mem_en, mem_we}), 128'(2'b11));
    @(negedge clk);
    checkOutput("pre-reset busy+ovf", 128'({rd_busy, ovf_err}), 128'(2'b11));
    #1 reset = 1'b1;
    #1 checkOutput("async reset outputs", 128'(allOut), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (mem_en || rresp_valid || bresp_valid || rd_busy || wr_busy) seen = 1'b1;
    end
    checkOutput("post-reset no activity", 128'(seen), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
